alu_secuencial: RTL and testbench
=================================

# alu_secuencial

Parametrised, multi-cycle successor to the 4-bit combinational ALU. It widens the datapath to N bits and adds XOR, shifts and an iterative shift-add multiply. Every operation runs under a start/done handshake, and result and NZCV flags are registered. It sits between the register-file read ports and the write-back/flag register of the datapath, and the control FSM drives it.

## Interface
- N, default 8: operand/result width, ≥4.
- SHW, default $clog2(N): width of the shift-amount field taken from SrcB[SHW-1:0].

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- start  in  1  request; sampled only when ready=1.
- operation  in  3  opcode, captured with start.
- SrcA  in  N  operand A, captured with start.
- SrcB  in  N  operand B, captured with start.
- ready  out  1  block can accept start this cycle.
- done  out  1  one-cycle pulse: result/flags valid.
- result  out  N  registered result, held until next done.
- Z, C, V, N_flag  out  1 each  registered flags, updated only with done.

## Operation
- Opcodes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR (logical), 111 MUL.
- AND, OR and XOR are bitwise over all N bits.
- States:
  - IDLE: ready=1. start moves to IDLE for single-cycle ops (done next cycle) or to MUL.
  - MUL: ready=0. An iteration counter runs 0..N-1. After the last iteration the FSM returns to IDLE and asserts done.
- Arithmetic is done in N+1 bits.
- ADD:
  - C = carry-out.
  - V = (A[N-1]==B[N-1]) && (R[N-1]!=A[N-1]).
- SUB: R = A + ~B + 1.
  - C = 1 when A ≥ B unsigned (no borrow).
  - V = (A[N-1]!=B[N-1]) && (R[N-1]!=A[N-1]).
- AND/OR/XOR: C=0, V=0.
- SHL/SHR: amount s = SrcB[SHW-1:0].
  - C = last bit shifted out.
  - s=0 gives R=A and C=0. V=0.
- MUL: unsigned shift-add, one partial-product step per cycle.
  - result = low N bits of A×B.
  - C = 1 if the high N bits are nonzero (truncation). V=0.
- All opcodes: Z = (R==0), N_flag = R[N-1].
- start while ready=0 is ignored; operands are not re-captured.
- Reset mid-MUL aborts the operation; no done is produced.

## Timing
- Reset values: result=0, Z=C=V=N_flag=0, done=0, ready=1, FSM=IDLE, counter=0.
- Single-cycle ops: start accepted at edge k; result, flags and done=1 visible after edge k (latency 1).
- MUL: start accepted at edge k; ready=0 after edge k; done=1 and ready=1 after edge k+N (latency N).
- done is high for exactly one cycle. ready=1 during the done cycle, so back-to-back start is accepted there with no bubble.
- Single-cycle ops issued every cycle give done every cycle.
- result and flags are stable between done pulses. Input changes while busy have no effect.

## Structure
- Shared package alu_pkg: the opcode constants (OP_ADD..OP_MUL), the FSM state encoding (S_IDLE, S_MUL) and the flag index constants.
- One natural sub-module, mul_iter: an N-bit shift-add multiplier with load/step inputs, the 2N-bit accumulator and a last-iteration indication. Everything else stays in alu_secuencial.

## Test plan
- N=4, ADD 0111+0001 → after 1 cycle result=1000, N=1, V=1, C=0, Z=0, done pulse 1 cycle.
- N=4, SUB 0011−0011 → result=0000, Z=1, C=1, V=0. SUB 0010−0011 → 1111, C=0, N=1.
- N=4, OR 1010|0101 → 1111; AND 1100&1010 → 1000; XOR 1111^1111 → 0000, Z=1 (bitwise, not logical).
- N=4, SHL A=1001 s=1 → 0010, C=1; SHR A=1001 s=3 → 0001, C=0; s=0 → 1001, C=0.
- N=4, MUL 0011×0101 → done exactly 4 cycles after start, result=1111, C=0. MUL 1111×1111 → 0001, C=1. start held during MUL is ignored and ready=0 throughout.
- rst_n=0 in the 2nd MUL cycle → next cycle ready=1, result=0, flags 0, no done. A following ADD completes normally. Back-to-back ADDs give done on consecutive cycles.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM state encoding and
// flag bit positions inside the packed flag vector.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 3;
  localparam int FLAG_W = 4;

endpackage

// File: rtl/mul_iter.sv
// Iterative unsigned shift-add multiplier: one partial-product step per cycle.
// acc_next exposes the post-step accumulator so the caller can register the
// product on the same edge as the final step.
module mul_iter
  import alu_pkg::*;
#(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic           step,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] acc_next,
  output logic           last
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;

  logic [2*N-1:0] acc_r;
  logic [N-1:0]   a_r;
  logic [CW-1:0]  cnt_r;
  logic [N:0]     sum_s;

  // Add the multiplicand into the upper half when the current multiplier bit is set, then shift right.
  always_comb begin
    sum_s    = {(N+1){1'b0}};
    acc_next = {(2*N){1'b0}};
    if (acc_r[0]) begin
      sum_s = {1'b0, acc_r[2*N-1:N]} + {1'b0, a_r};
    end else begin
      sum_s = {1'b0, acc_r[2*N-1:N]};
    end
    acc_next = {sum_s, acc_r[N-1:1]};
  end

  assign last = (cnt_r == CW'(N-1));

  // Accumulator, multiplicand and iteration counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_r <= {(2*N){1'b0}};
      a_r   <= {N{1'b0}};
      cnt_r <= {CW{1'b0}};
    end else if (load) begin
      acc_r <= {{N{1'b0}}, b};
      a_r   <= a;
      cnt_r <= {CW{1'b0}};
    end else if (step) begin
      acc_r <= acc_next;
      if (last) begin
        cnt_r <= {CW{1'b0}};
      end else begin
        cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
      end
    end else begin
      acc_r <= acc_r;
      a_r   <= a_r;
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/alu_secuencial.sv
// N-bit multi-cycle ALU with start/done handshake and registered result/NZCV.
// Single-cycle ops complete one edge after start; MUL takes N edges.
module alu_secuencial
  import alu_pkg::*;
#(
  parameter int N   = 8,
  parameter int SHW = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [2:0]   operation,
  input  logic [N-1:0] SrcA,
  input  logic [N-1:0] SrcB,
  output logic         ready,
  output logic         done,
  output logic [N-1:0] result,
  output logic         Z,
  output logic         C,
  output logic         V,
  output logic         N_flag
);

  state_t              state_r;
  logic                ready_r;
  logic                done_r;
  logic [N-1:0]        result_r;
  logic [FLAG_W-1:0]   flags_r;

  logic [N:0]          ext_s;
  logic [N-1:0]        alu_res_s;
  logic                alu_c_s;
  logic                alu_v_s;
  logic [FLAG_W-1:0]   alu_flags_s;
  logic [SHW-1:0]      shamt_s;

  logic                mul_load_s;
  logic                mul_step_s;
  logic [2*N-1:0]      mul_acc_next_s;
  logic                mul_last_s;
  logic [FLAG_W-1:0]   mul_flags_s;

  assign shamt_s    = SrcB[SHW-1:0];
  assign mul_load_s = (state_r == S_IDLE) && start && (operation == OP_MUL);
  assign mul_step_s = (state_r == S_MUL);

  mul_iter #(.N(N)) u_mul (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (mul_load_s),
    .step     (mul_step_s),
    .a        (SrcA),
    .b        (SrcB),
    .acc_next (mul_acc_next_s),
    .last     (mul_last_s)
  );

  // Single-cycle datapath; shifts run one bit wider so the ejected bit lands in the extension.
  always_comb begin
    ext_s     = {(N+1){1'b0}};
    alu_res_s = {N{1'b0}};
    alu_c_s   = 1'b0;
    alu_v_s   = 1'b0;
    case (operation)
      OP_ADD: begin
        ext_s     = {1'b0, SrcA} + {1'b0, SrcB};
        alu_res_s = ext_s[N-1:0];
        alu_c_s   = ext_s[N];
        alu_v_s   = (SrcA[N-1] == SrcB[N-1]) && (ext_s[N-1] != SrcA[N-1]);
      end
      OP_SUB: begin
        ext_s     = {1'b0, SrcA} + {1'b0, ~SrcB} + {{N{1'b0}}, 1'b1};
        alu_res_s = ext_s[N-1:0];
        alu_c_s   = ext_s[N];
        alu_v_s   = (SrcA[N-1] != SrcB[N-1]) && (ext_s[N-1] != SrcA[N-1]);
      end
      OP_AND: alu_res_s = SrcA & SrcB;
      OP_OR:  alu_res_s = SrcA | SrcB;
      OP_XOR: alu_res_s = SrcA ^ SrcB;
      OP_SHL: begin
        ext_s     = {1'b0, SrcA} << shamt_s;
        alu_res_s = ext_s[N-1:0];
        alu_c_s   = ext_s[N];
      end
      OP_SHR: begin
        ext_s     = {SrcA, 1'b0} >> shamt_s;
        alu_res_s = ext_s[N:1];
        alu_c_s   = ext_s[0];
      end
      default: begin
        ext_s     = {(N+1){1'b0}};
        alu_res_s = {N{1'b0}};
      end
    endcase
  end

  // Flag vectors for the single-cycle and multiply completions.
  always_comb begin
    alu_flags_s         = {FLAG_W{1'b0}};
    alu_flags_s[FLAG_Z] = (alu_res_s == {N{1'b0}});
    alu_flags_s[FLAG_C] = alu_c_s;
    alu_flags_s[FLAG_V] = alu_v_s;
    alu_flags_s[FLAG_N] = alu_res_s[N-1];
    mul_flags_s         = {FLAG_W{1'b0}};
    mul_flags_s[FLAG_Z] = (mul_acc_next_s[N-1:0] == {N{1'b0}});
    mul_flags_s[FLAG_C] = (mul_acc_next_s[2*N-1:N] != {N{1'b0}});
    mul_flags_s[FLAG_V] = 1'b0;
    mul_flags_s[FLAG_N] = mul_acc_next_s[N-1];
  end

  // Control FSM with registered handshake, result and flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= S_IDLE;
      ready_r  <= 1'b1;
      done_r   <= 1'b0;
      result_r <= {N{1'b0}};
      flags_r  <= {FLAG_W{1'b0}};
    end else begin
      done_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (start && (operation == OP_MUL)) begin
            state_r <= S_MUL;
            ready_r <= 1'b0;
          end else if (start) begin
            done_r   <= 1'b1;
            result_r <= alu_res_s;
            flags_r  <= alu_flags_s;
          end else begin
            ready_r <= 1'b1;
          end
        end
        S_MUL: begin
          if (mul_last_s) begin
            state_r  <= S_IDLE;
            ready_r  <= 1'b1;
            done_r   <= 1'b1;
            result_r <= mul_acc_next_s[N-1:0];
            flags_r  <= mul_flags_s;
          end else begin
            ready_r <= 1'b0;
          end
        end
        default: begin
          state_r <= S_IDLE;
          ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign ready  = ready_r;
  assign done   = done_r;
  assign result = result_r;
  assign Z      = flags_r[FLAG_Z];
  assign C      = flags_r[FLAG_C];
  assign V      = flags_r[FLAG_V];
  assign N_flag = flags_r[FLAG_N];

endmodule

// File: tb/tb_alu_secuencial.sv
// Directed bench for alu_secuencial at N=4; flags compared as {N,Z,C,V}.
module tb_alu_secuencial;
  import alu_pkg::*;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [2:0]   operation;
  logic [N-1:0] SrcA;
  logic [N-1:0] SrcB;
  logic         ready;
  logic         done;
  logic [N-1:0] result;
  logic         Z;
  logic         C;
  logic         V;
  logic         N_flag;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_secuencial #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .operation (operation),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .ready     (ready),
    .done      (done),
    .result    (result),
    .Z         (Z),
    .C         (C),
    .V         (V),
    .N_flag    (N_flag)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic single(input string tag, input logic [2:0] op, input logic [3:0] a,
                        input logic [3:0] b, input logic [3:0] er, input logic [3:0] ef);
    operation = op;
    SrcA      = a;
    SrcB      = b;
    start     = 1'b1;
    step();
    start = 1'b0;
    check({tag, ".done"}, {7'd0, done}, 8'd1);
    check({tag, ".result"}, {4'd0, result}, {4'd0, er});
    check({tag, ".flags"}, {4'd0, N_flag, Z, C, V}, {4'd0, ef});
  endtask

  task automatic mul(input string tag, input logic [3:0] a, input logic [3:0] b,
                     input logic [3:0] er, input logic [3:0] ef, input bit hold);
    operation = OP_MUL;
    SrcA      = a;
    SrcB      = b;
    start     = 1'b1;
    step();
    if (hold) begin
      operation = OP_ADD;
      SrcA      = 4'h0;
      SrcB      = 4'h1;
    end else begin
      start = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      check($sformatf("%s.busy_ready%0d", tag, i), {7'd0, ready}, 8'd0);
      check($sformatf("%s.busy_done%0d", tag, i), {7'd0, done}, 8'd0);
      step();
    end
    start = 1'b0;
    check({tag, ".done"}, {7'd0, done}, 8'd1);
    check({tag, ".ready"}, {7'd0, ready}, 8'd1);
    check({tag, ".result"}, {4'd0, result}, {4'd0, er});
    check({tag, ".flags"}, {4'd0, N_flag, Z, C, V}, {4'd0, ef});
    step();
    check({tag, ".done_low"}, {7'd0, done}, 8'd0);
    check({tag, ".hold"}, {4'd0, result}, {4'd0, er});
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    operation = 3'b000;
    SrcA      = 4'h0;
    SrcB      = 4'h0;
    step();
    step();
    check("rst.ready", {7'd0, ready}, 8'd1);
    check("rst.done", {7'd0, done}, 8'd0);
    check("rst.result", {4'd0, result}, 8'd0);
    check("rst.flags", {4'd0, N_flag, Z, C, V}, 8'd0);
    rst_n = 1'b1;
    step();

    single("add7p1", OP_ADD, 4'b0111, 4'b0001, 4'b1000, 4'b1001);
    step();
    check("add7p1.done_low", {7'd0, done}, 8'd0);
    check("add7p1.hold", {4'd0, result}, 8'h08);

    single("sub3m3", OP_SUB, 4'b0011, 4'b0011, 4'b0000, 4'b0110);
    single("sub2m3", OP_SUB, 4'b0010, 4'b0011, 4'b1111, 4'b1000);
    single("or",     OP_OR,  4'b1010, 4'b0101, 4'b1111, 4'b1000);
    single("and",    OP_AND, 4'b1100, 4'b1010, 4'b1000, 4'b1000);
    single("xor",    OP_XOR, 4'b1111, 4'b1111, 4'b0000, 4'b0100);
    single("shl1",   OP_SHL, 4'b1001, 4'b0001, 4'b0010, 4'b0010);
    single("shr3",   OP_SHR, 4'b1001, 4'b0011, 4'b0001, 4'b0000);
    single("shr0",   OP_SHR, 4'b1001, 4'b0000, 4'b1001, 4'b1000);

    mul("mul3x5", 4'b0011, 4'b0101, 4'b1111, 4'b1000, 1'b1);
    mul("mulFxF", 4'b1111, 4'b1111, 4'b0001, 4'b0010, 1'b0);

    // Abort a multiply with reset during its second cycle.
    operation = OP_MUL;
    SrcA      = 4'b0011;
    SrcB      = 4'b0101;
    start     = 1'b1;
    step();
    start = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    check("abort.ready", {7'd0, ready}, 8'd1);
    check("abort.done", {7'd0, done}, 8'd0);
    check("abort.result", {4'd0, result}, 8'd0);
    check("abort.flags", {4'd0, N_flag, Z, C, V}, 8'd0);
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) begin
      step();
      check($sformatf("abort.no_done%0d", i), {7'd0, done}, 8'd0);
    end
    single("add_after_abort", OP_ADD, 4'b0001, 4'b0010, 4'b0011, 4'b0000);

    // Back-to-back single-cycle ops.
    operation = OP_ADD;
    SrcA      = 4'b0001;
    SrcB      = 4'b0001;
    start     = 1'b1;
    step();
    check("b2b1.done", {7'd0, done}, 8'd1);
    check("b2b1.result", {4'd0, result}, 8'h02);
    SrcA = 4'b0010;
    SrcB = 4'b0011;
    step();
    check("b2b2.done", {7'd0, done}, 8'd1);
    check("b2b2.result", {4'd0, result}, 8'h05);
    start = 1'b0;
    step();
    check("b2b.done_low", {7'd0, done}, 8'd0);
    check("b2b.hold", {4'd0, result}, 8'h05);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
